// File: rtl/imem_pkg.sv
// imem_pkg -- shared types and constants for the bootable instruction memory.
//   state_t    : controller state (LOAD = accepting image bytes, RUN = serving fetches)
//   NOP_INSN   : addi x0,x0,0, returned for fetches outside the loaded image
//   imem_depth : word depth for a given byte-address width
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic int imem_depth(input int addr_w);
    return 1 << (addr_w - 2);
  endfunction

endpackage

// File: rtl/imem_byte_asm.sv
// imem_byte_asm -- packs the little-endian load byte stream into 32-bit words.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_clear         : restart assembly at lane 0 (reload)
//   i_byte_fire     : a byte is accepted this cycle
//   i_byte          : accepted byte
//   i_last          : accepted byte is the final byte of the image
//   o_wr_stb        : full (or last, zero-filled) word is ready this cycle
//   o_wr_data       : word to write, valid with o_wr_stb
module imem_byte_asm (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byte_fire,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_wr_stb,
  output logic [31:0] o_wr_data
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [31:0] w_merged;

  // r_word is cleared after every emitted word, so lanes above the current
  // one are already zero -- that gives the zero-fill on a short last word.
  always_comb begin
    w_merged  = r_word | (32'(i_byte) << {r_lane, 3'b000});
    o_wr_stb  = i_byte_fire && (i_last || (r_lane == 2'd3));
    o_wr_data = w_merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (i_byte_fire) begin
      if (o_wr_stb) begin
        r_lane <= 2'd0;
        r_word <= 32'd0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_word <= w_merged;
      end
    end
  end

endmodule

// File: rtl/imem_loaded.sv
// imem_loaded -- instruction memory filled at run time from a byte stream,
// then serving fetches through a registered request/response handshake.
// Optional feature: define IMEM_PARITY_EN to store and check one even-parity
// bit per word; otherwise o_rsp_parity_err is tied low.
// Ports:
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_load_valid/o_load_ready          : load byte handshake (ready only in LOAD)
//   i_load_byte, i_load_last           : image byte, final-byte marker
//   i_reload                           : pulse in RUN to restart loading
//   i_req_valid/o_req_ready, i_req_addr: fetch request (byte address)
//   o_rsp_valid/i_rsp_ready            : fetch response handshake
//   o_rsp_data, o_rsp_misalign         : instruction word, low address bits nonzero
//   o_rsp_parity_err                   : stored parity mismatch on this word
//   o_boot_done                        : image loaded, fetches enabled
//   o_load_words                       : words written in the current image
// INS_W must be 32: the loader assembles four bytes per word.
module imem_loaded
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [7:0]             i_load_byte,
  input  logic                   i_load_last,
  input  logic                   i_reload,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [INS_ADDRESS-1:0] i_req_addr,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [INS_W-1:0]       o_rsp_data,
  output logic                   o_rsp_misalign,
  output logic                   o_rsp_parity_err,
  output logic                   o_boot_done,
  output logic [INS_ADDRESS-2:0] o_load_words
);

  localparam int DEPTH = imem_depth(INS_ADDRESS);
  localparam int LW    = INS_ADDRESS - 1;
  localparam int IW    = INS_ADDRESS - 2;
  localparam logic [LW-1:0] LAST_IDX = LW'(DEPTH - 1);

  state_t          r_state;
  logic [LW-1:0]   r_load_words;
  logic            r_rsp_valid;
  logic [INS_W-1:0] r_rsp_data;
  logic            r_rsp_misalign;
  logic [INS_W-1:0] r_mem [DEPTH];

  logic            w_load_fire;
  logic            w_wr_stb;
  logic [31:0]     w_wr_data;
  logic            w_req_fire;
  logic [IW-1:0]   w_idx;
  logic            w_in_image;
  logic            w_reload_run;

  assign o_load_ready = (r_state == LOAD);
  assign o_boot_done  = (r_state == RUN);
  assign o_load_words = r_load_words;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_misalign = r_rsp_misalign;

  assign w_load_fire  = i_load_valid && o_load_ready;
  assign w_reload_run = i_reload && (r_state == RUN);
  assign o_req_ready  = o_boot_done && !i_reload && (!r_rsp_valid || i_rsp_ready);
  assign w_req_fire   = i_req_valid && o_req_ready;
  assign w_idx        = i_req_addr[INS_ADDRESS-1:2];
  assign w_in_image   = ({1'b0, w_idx} < r_load_words);

  imem_byte_asm u_asm (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_reload_run),
    .i_byte_fire (w_load_fire),
    .i_byte      (i_load_byte),
    .i_last      (i_load_last),
    .o_wr_stb    (w_wr_stb),
    .o_wr_data   (w_wr_data)
  );

  // Storage is deliberately not reset; r_load_words bounds valid content.
  // In LOAD r_load_words < DEPTH, so its low IW bits are a valid index.
  always_ff @(posedge i_clk) begin
    if (w_wr_stb) begin
      r_mem[r_load_words[IW-1:0]] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= LOAD;
      r_load_words   <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_misalign <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_wr_stb) begin
            r_load_words <= r_load_words + 1'b1;
            // Filling the last word ends loading even without load_last.
            if (i_load_last || (r_load_words == LAST_IDX)) begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_reload) begin
            r_state      <= LOAD;
            r_load_words <= '0;
            r_rsp_valid  <= 1'b0;
          end else if (w_req_fire) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_data     <= w_in_image ? r_mem[w_idx] : NOP_INSN;
            r_rsp_misalign <= (i_req_addr[1:0] != 2'b00);
          end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_rsp_parity_err;

  always_ff @(posedge i_clk) begin
    if (w_wr_stb) begin
      r_par[r_load_words[IW-1:0]] <= ^w_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_parity_err <= 1'b0;
    end else if ((r_state == RUN) && w_req_fire) begin
      r_rsp_parity_err <= w_in_image && (r_par[w_idx] ^ (^r_mem[w_idx]));
    end
  end

  assign o_rsp_parity_err = r_rsp_parity_err;
`else
  assign o_rsp_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loaded.sv
// tb_imem_loaded -- directed bench for imem_loaded (INS_ADDRESS=4, 4-word depth).
module tb_imem_loaded;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [7:0]    load_byte;
  logic          load_last;
  logic          reload;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_misalign;
  logic          rsp_parity_err;
  logic          boot_done;
  logic [AW-2:0] load_words;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loaded #(.INS_ADDRESS(AW), .INS_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_load_valid     (load_valid),
    .o_load_ready     (load_ready),
    .i_load_byte      (load_byte),
    .i_load_last      (load_last),
    .i_reload         (reload),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_addr       (req_addr),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_data       (rsp_data),
    .o_rsp_misalign   (rsp_misalign),
    .o_rsp_parity_err (rsp_parity_err),
    .o_boot_done      (boot_done),
    .o_load_words     (load_words)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    #1;
    chk("load_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic mis, input logic perr);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_misalign"}, 32'(rsp_misalign), 32'(mis));
    chk({tag, "_parity"}, 32'(rsp_parity_err), 32'(perr));
  endtask

  initial begin
    logic [AW-1:0] b2b_addr [4];
    logic [31:0]   b2b_data [4];
    logic          b2b_mis  [4];
    b2b_addr = '{4'h4, 4'h8, 4'h0, 4'h6};
    b2b_data = '{32'h0020_0093, 32'h0000_0013, 32'h0010_0013, 32'h0020_0093};
    b2b_mis  = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
    reload = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_load_words", 32'(load_words), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_misalign", 32'(rsp_misalign), 32'd0);
    chk("rst_parity", 32'(rsp_parity_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Two-word image
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
    chk("img1_words_after_w0", 32'(load_words), 32'd1);
    chk("img1_boot_mid", 32'(boot_done), 32'd0);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b1);
    chk("img1_load_words", 32'(load_words), 32'd2);
    chk("img1_boot_done", 32'(boot_done), 32'd1);
    chk("img1_load_ready", 32'(load_ready), 32'd0);

    fetch("f000", 4'h0, 32'h0010_0013, 1'b0, 1'b0);
    fetch("f004", 4'h4, 32'h0020_0093, 1'b0, 1'b0);
    fetch("f008_nop", 4'h8, 32'h0000_0013, 1'b0, 1'b0);
    fetch("f006_mis", 4'h6, 32'h0020_0093, 1'b1, 1'b0);
    tick();
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Stall then back-to-back
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'h0;
    #1;
    chk("stall_first_ready", 32'(req_ready), 32'd1);
    tick();
    req_addr = 4'h4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, 32'h0010_0013);
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = b2b_addr[i];
      #1;
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      tick();
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_rsp_data", rsp_data, b2b_data[i]);
      chk("b2b_misalign", 32'(rsp_misalign), 32'(b2b_mis[i]));
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(rsp_valid), 32'd0);

    // Reload with a concurrent request
    reload    = 1'b1;
    req_valid = 1'b1;
    req_addr  = 4'h0;
    #1;
    chk("reload_req_ready", 32'(req_ready), 32'd0);
    tick();
    reload    = 1'b0;
    req_valid = 1'b0;
    chk("reload_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reload_load_words", 32'(load_words), 32'd0);
    chk("reload_load_ready", 32'(load_ready), 32'd1);
    chk("reload_boot_done", 32'(boot_done), 32'd0);

    // Five-byte image, short last word zero-filled
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'hAA, 1'b1);
    chk("img5_load_words", 32'(load_words), 32'd2);
    chk("img5_boot_done", 32'(boot_done), 32'd1);
    fetch("img5_w0", 4'h0, 32'h4433_2211, 1'b0, 1'b0);
    fetch("img5_w1", 4'h4, 32'h0000_00AA, 1'b0, 1'b0);
    fetch("img5_nop", 4'h8, 32'h0000_0013, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a word
    reload = 1'b1;
    tick();
    reload = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_load_words", 32'(load_words), 32'd0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b1);
    chk("midrst_words", 32'(load_words), 32'd1);
    fetch("midrst_w0", 4'h0, 32'h8877_6655, 1'b0, 1'b0);
    fetch("midrst_nop", 4'h4, 32'h0000_0013, 1'b0, 1'b0);
    tick();

    // Fill to depth without load_last
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b0);
    chk("fill_boot_before", 32'(boot_done), 32'd0);
    chk("fill_words_before", 32'(load_words), 32'd3);
    send_byte(8'h0F, 1'b0);
    chk("fill_load_words", 32'(load_words), 32'd4);
    chk("fill_boot_done", 32'(boot_done), 32'd1);
    chk("fill_load_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_byte  = 8'hEE;
    tick();
    load_valid = 1'b0;
    chk("fill_no_accept", 32'(load_words), 32'd4);
    fetch("fill_w3", 4'hC, 32'h0F0E_0D0C, 1'b0, 1'b0);
    fetch("fill_w0", 4'h0, 32'h0302_0100, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.r_mem[2] = dut.r_mem[2] ^ 32'h0000_0001;
    fetch("par_bad", 4'h8, 32'h0B0A_0909, 1'b0, 1'b1);
    fetch("par_good", 4'h4, 32'h0706_0504, 1'b0, 1'b0);
`else
    fetch("par_off", 4'h8, 32'h0B0A_0908, 1'b0, 1'b0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
